kcpsmx_operand_stage: RTL and testbench

//  ID->EX operand stage of the pipelined KCPSMX core; directly upstream of the ALU, consumer of the register file read ports.

---
 rtl/kcpsmx_operand_stage_pkg.sv | 27 ++
 rtl/kcpsmx_operand_stage_if.sv | 19 +
 rtl/kcpsmx_operand_stage_fwd_mux.sv | 28 ++
 rtl/kcpsmx_operand_stage.sv | 91 +++++++++
 tb/tb_kcpsmx_operand_stage.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/kcpsmx_operand_stage_pkg.sv
// Shared constants, opcodes and the ID/EX register layout for the KCPSMX operand stage.
package kcpsmx3_inc;
    localparam int REGISTER_DEPTH = 4;
    localparam int REGISTER_WIDTH = 8;
    localparam int KX_OP_W        = 6;
    localparam int KX_STALL_W     = 16;

    typedef enum logic [KX_OP_W-1:0] {
        OP_LOAD  = 6'h00,
        OP_AND   = 6'h0A,
        OP_OR    = 6'h0C,
        OP_XOR   = 6'h0E,
        OP_ADD   = 6'h18,
        OP_ADDCY = 6'h1A,
        OP_SUB   = 6'h1C,
        OP_INPUT = 6'h04,
        OP_FETCH = 6'h06
    } opcode_e;

    typedef struct packed {
        logic                      valid;
        logic [KX_OP_W-1:0]        op;
        logic [REGISTER_DEPTH-1:0] sx_addr;
        logic [REGISTER_WIDTH-1:0] a;
        logic [REGISTER_WIDTH-1:0] b;
    } idex_t;
endpackage

// File: rtl/kcpsmx_operand_stage_if.sv
// Decoded-instruction handshake between the decoder (master) and the operand stage (slave).
interface kcpsmx_operand_stage_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int OP_W   = 6
);
    logic              id_valid;
    logic              id_ready;
    logic [OP_W-1:0]   id_op;
    logic [ADDR_W-1:0] id_sx_addr;
    logic [ADDR_W-1:0] id_sy_addr;
    logic              id_use_sy;
    logic [DATA_W-1:0] id_kk;

    modport master (output id_valid, id_op, id_sx_addr, id_sy_addr, id_use_sy, id_kk,
                    input  id_ready);
    modport slave  (input  id_valid, id_op, id_sx_addr, id_sy_addr, id_use_sy, id_kk,
                    output id_ready);
endinterface

// File: rtl/kcpsmx_operand_stage_fwd_mux.sv
// Operand source select for one register read: EX result > WB result > register file.
module kcpsmx_fwd_mux #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_ex_en,
    input  logic [ADDR_W-1:0] i_ex_addr,
    input  logic [DATA_W-1:0] i_ex_data,
    input  logic              i_ex_late,
    input  logic              i_wb_en,
    input  logic [ADDR_W-1:0] i_wb_addr,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic [DATA_W-1:0] i_rf_data,
    output logic [DATA_W-1:0] o_data
);
    logic w_ex_hit, w_wb_hit;

    // A late EX hit never selects here; the top stalls instead.
    assign w_ex_hit = i_ex_en & ~i_ex_late & (i_ex_addr == i_addr);
    assign w_wb_hit = i_wb_en & (i_wb_addr == i_addr);

    always_comb begin
        o_data = i_rf_data;
        if (w_ex_hit)      o_data = i_ex_data;
        else if (w_wb_hit) o_data = i_wb_data;
    end
endmodule

// File: rtl/kcpsmx_operand_stage.sv
// ID->EX operand stage: register reads, EX/WB forwarding, load-use stall and the ID/EX register.
module kcpsmx_operand_stage
    import kcpsmx3_inc::*;
#(
    parameter int ADDR_W  = REGISTER_DEPTH,
    parameter int DATA_W  = REGISTER_WIDTH,
    parameter int OP_W    = KX_OP_W,
    parameter int STALL_W = KX_STALL_W
) (
    input  logic                clk,
    input  logic                reset,
    kcpsmx_operand_stage_if.slave id,
    input  logic                flush,
    output logic [ADDR_W-1:0]   rf_x_address,
    output logic [ADDR_W-1:0]   rf_y_address,
    input  logic [DATA_W-1:0]   rf_x_data,
    input  logic [DATA_W-1:0]   rf_y_data,
    input  logic                ex_wr_en,
    input  logic [ADDR_W-1:0]   ex_wr_addr,
    input  logic [DATA_W-1:0]   ex_wr_data,
    input  logic                ex_wr_late,
    input  logic                wb_wr_en,
    input  logic [ADDR_W-1:0]   wb_wr_addr,
    input  logic [DATA_W-1:0]   wb_wr_data,
    input  logic                ex_ready,
    output logic                idex_valid,
    output logic [OP_W-1:0]     idex_op,
    output logic [ADDR_W-1:0]   idex_sx_addr,
    output logic [DATA_W-1:0]   idex_a,
    output logic [DATA_W-1:0]   idex_b,
    output logic [STALL_W-1:0]  stall_count
);
    idex_t              r_idex;
    logic [STALL_W-1:0] r_stall;
    logic [DATA_W-1:0]  w_a, w_y, w_b;
    logic               w_hazard, w_ready, w_accept;

    assign rf_x_address = id.id_sx_addr;
    assign rf_y_address = id.id_sy_addr;

    kcpsmx_fwd_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_x (
        .i_addr(id.id_sx_addr), .i_ex_en(ex_wr_en), .i_ex_addr(ex_wr_addr),
        .i_ex_data(ex_wr_data), .i_ex_late(ex_wr_late), .i_wb_en(wb_wr_en),
        .i_wb_addr(wb_wr_addr), .i_wb_data(wb_wr_data), .i_rf_data(rf_x_data),
        .o_data(w_a));

    kcpsmx_fwd_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_y (
        .i_addr(id.id_sy_addr), .i_ex_en(ex_wr_en), .i_ex_addr(ex_wr_addr),
        .i_ex_data(ex_wr_data), .i_ex_late(ex_wr_late), .i_wb_en(wb_wr_en),
        .i_wb_addr(wb_wr_addr), .i_wb_data(wb_wr_data), .i_rf_data(rf_y_data),
        .o_data(w_y));

    // Immediate operands bypass forwarding and cannot create a hazard.
    assign w_b      = id.id_use_sy ? w_y : id.id_kk;
    assign w_hazard = id.id_valid & ex_wr_en & ex_wr_late &
                      ((ex_wr_addr == id.id_sx_addr) |
                       (id.id_use_sy & (ex_wr_addr == id.id_sy_addr)));
    assign w_ready  = ~w_hazard & (ex_ready | ~r_idex.valid);
    assign w_accept = id.id_valid & w_ready;
    assign id.id_ready = w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idex <= '0;
        end else if (flush) begin
            r_idex.valid <= 1'b0;
        end else if (w_accept) begin
            r_idex.valid   <= 1'b1;
            r_idex.op      <= id.id_op;
            r_idex.sx_addr <= id.id_sx_addr;
            r_idex.a       <= w_a;
            r_idex.b       <= w_b;
        end else if (ex_ready) begin
            r_idex.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stall <= '0;
        else if (id.id_valid & ~w_ready & ~flush & (r_stall != '1))
            r_stall <= r_stall + STALL_W'(1);
    end

    assign idex_valid   = r_idex.valid;
    assign idex_op      = r_idex.op;
    assign idex_sx_addr = r_idex.sx_addr;
    assign idex_a       = r_idex.a;
    assign idex_b       = r_idex.b;
    assign stall_count  = r_stall;
endmodule

// File: tb/tb_kcpsmx_operand_stage.sv
// Directed bench for kcpsmx_operand_stage with a narrow-counter instance for saturation.
module tb_kcpsmx_operand_stage;
    import kcpsmx3_inc::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    kcpsmx_operand_stage_if #(.ADDR_W(4), .DATA_W(8), .OP_W(6)) idb ();
    kcpsmx_operand_stage_if #(.ADDR_W(4), .DATA_W(8), .OP_W(6)) sdb ();

    logic       flush, ex_wr_en, ex_wr_late, wb_wr_en, ex_ready;
    logic [3:0] ex_wr_addr, wb_wr_addr, rf_x_address, rf_y_address;
    logic [7:0] ex_wr_data, wb_wr_data, rf_x_data, rf_y_data;
    logic       idex_valid;
    logic [5:0] idex_op;
    logic [3:0] idex_sx_addr;
    logic [7:0] idex_a, idex_b;
    logic [15:0] stall_count;
    logic [7:0] rf_mem [16];

    assign rf_x_data = rf_mem[rf_x_address];
    assign rf_y_data = rf_mem[rf_y_address];

    kcpsmx_operand_stage dut (
        .clk(clk), .reset(reset), .id(idb.slave), .flush(flush),
        .rf_x_address(rf_x_address), .rf_y_address(rf_y_address),
        .rf_x_data(rf_x_data), .rf_y_data(rf_y_data),
        .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data),
        .ex_wr_late(ex_wr_late), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
        .wb_wr_data(wb_wr_data), .ex_ready(ex_ready), .idex_valid(idex_valid),
        .idex_op(idex_op), .idex_sx_addr(idex_sx_addr), .idex_a(idex_a),
        .idex_b(idex_b), .stall_count(stall_count));

    // Permanently stalled instance: late EX writer to s0 while ID keeps reading s0.
    logic [3:0] s_xa, s_ya;
    logic       s_valid;
    logic [5:0] s_op;
    logic [3:0] s_sx;
    logic [7:0] s_a, s_b;
    logic [2:0] s_cnt;

    assign sdb.id_valid = 1'b1;
    assign sdb.id_op = 6'h00;
    assign sdb.id_sx_addr = 4'h0;
    assign sdb.id_sy_addr = 4'h1;
    assign sdb.id_use_sy = 1'b0;
    assign sdb.id_kk = 8'h00;

    kcpsmx_operand_stage #(.STALL_W(3)) u_sat (
        .clk(clk), .reset(reset), .id(sdb.slave), .flush(1'b0),
        .rf_x_address(s_xa), .rf_y_address(s_ya), .rf_x_data(8'h00), .rf_y_data(8'h00),
        .ex_wr_en(1'b1), .ex_wr_addr(4'h0), .ex_wr_data(8'h00), .ex_wr_late(1'b1),
        .wb_wr_en(1'b0), .wb_wr_addr(4'h0), .wb_wr_data(8'h00), .ex_ready(1'b1),
        .idex_valid(s_valid), .idex_op(s_op), .idex_sx_addr(s_sx), .idex_a(s_a),
        .idex_b(s_b), .stall_count(s_cnt));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [3:0] sx, input logic [3:0] sy,
                         input logic use_sy, input logic [7:0] kk);
        idb.id_valid   = 1'b1;
        idb.id_op      = op;
        idb.id_sx_addr = sx;
        idb.id_sy_addr = sy;
        idb.id_use_sy  = use_sy;
        idb.id_kk      = kk;
    endtask

    task automatic set_ex(input logic en, input logic [3:0] a, input logic [7:0] d, input logic late);
        ex_wr_en = en; ex_wr_addr = a; ex_wr_data = d; ex_wr_late = late;
    endtask

    task automatic set_wb(input logic en, input logic [3:0] a, input logic [7:0] d);
        wb_wr_en = en; wb_wr_addr = a; wb_wr_data = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rf_mem[i] = 8'h00;
        rf_mem[3] = 8'h12; rf_mem[4] = 8'h34; rf_mem[5] = 8'h55;
        reset = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        idb.id_valid = 1'b0; idb.id_op = '0; idb.id_sx_addr = '0;
        idb.id_sy_addr = '0; idb.id_use_sy = 1'b0; idb.id_kk = '0;
        set_ex(1'b0, 4'h0, 8'h00, 1'b0);
        set_wb(1'b0, 4'h0, 8'h00);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_valid", idex_valid, 0);
        chk("rst_a", idex_a, 0);
        chk("rst_b", idex_b, 0);
        chk("rst_stall", stall_count, 0);
        chk("rst_ready", idb.id_ready, 1);

        // plain issue
        issue(OP_ADD, 4'd3, 4'd4, 1'b1, 8'h00);
        #1;
        chk("rf_x_addr", rf_x_address, 3);
        chk("rf_y_addr", rf_y_address, 4);
        tick();
        chk("t1_valid", idex_valid, 1);
        chk("t1_a", idex_a, 8'h12);
        chk("t1_b", idex_b, 8'h34);
        chk("t1_sx", idex_sx_addr, 3);
        chk("t1_op", idex_op, OP_ADD);

        // EX forward, back-to-back
        set_ex(1'b1, 4'd3, 8'hA5, 1'b0);
        issue(OP_SUB, 4'd3, 4'd4, 1'b1, 8'h00);
        #1;
        chk("t2_ready", idb.id_ready, 1);
        tick();
        chk("t2_a", idex_a, 8'hA5);
        chk("t2_b", idex_b, 8'h34);
        chk("t2_op", idex_op, OP_SUB);
        chk("t2_stall", stall_count, 0);

        // EX beats WB on same address
        set_ex(1'b1, 4'd5, 8'h01, 1'b0);
        set_wb(1'b1, 4'd5, 8'h02);
        issue(OP_OR, 4'd4, 4'd5, 1'b1, 8'h00);
        tick();
        chk("t3_a", idex_a, 8'h34);
        chk("t3_b", idex_b, 8'h01);

        // same register on both sources, WB only
        set_ex(1'b0, 4'd0, 8'h00, 1'b0);
        issue(OP_XOR, 4'd5, 4'd5, 1'b1, 8'h00);
        tick();
        chk("t3s_a", idex_a, 8'h02);
        chk("t3s_b", idex_b, 8'h02);

        // load-use: late producer of s2
        set_wb(1'b0, 4'd0, 8'h00);
        set_ex(1'b1, 4'd2, 8'h00, 1'b1);
        issue(OP_ADD, 4'd2, 4'd4, 1'b1, 8'h00);
        #1;
        chk("t4_ready0", idb.id_ready, 0);
        tick();
        chk("t4_bubble", idex_valid, 0);
        chk("t4_stall", stall_count, 1);
        set_ex(1'b0, 4'd0, 8'h00, 1'b0);
        set_wb(1'b1, 4'd2, 8'h7E);
        #1;
        chk("t4_ready1", idb.id_ready, 1);
        tick();
        chk("t4_valid", idex_valid, 1);
        chk("t4_a", idex_a, 8'h7E);
        chk("t4_b", idex_b, 8'h34);
        chk("t4_stall2", stall_count, 1);
        set_wb(1'b0, 4'd0, 8'h00);

        // immediate ignores late sY match
        set_ex(1'b1, 4'd6, 8'h00, 1'b1);
        issue(OP_LOAD, 4'd3, 4'd6, 1'b0, 8'hFF);
        #1;
        chk("t5_ready", idb.id_ready, 1);
        tick();
        chk("t5_a", idex_a, 8'h12);
        chk("t5_b", idex_b, 8'hFF);
        chk("t5_stall", stall_count, 1);
        set_ex(1'b0, 4'd0, 8'h00, 1'b0);

        // backpressure hold
        issue(OP_AND, 4'd4, 4'd3, 1'b1, 8'h00);
        tick();
        chk("t6_a0", idex_a, 8'h34);
        ex_ready = 1'b0;
        issue(OP_ADDCY, 4'd3, 4'd5, 1'b1, 8'h00);
        #1;
        chk("t6_ready", idb.id_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_hold_v", idex_valid, 1);
            chk("t6_hold_a", idex_a, 8'h34);
            chk("t6_hold_b", idex_b, 8'h12);
            chk("t6_hold_op", idex_op, OP_AND);
        end
        chk("t6_stall", stall_count, 4);

        // flush kills ID/EX, no stall counted
        flush = 1'b1;
        tick();
        chk("t6_flush_v", idex_valid, 0);
        chk("t6_flush_st", stall_count, 4);
        flush = 1'b0;

        // refill, stall once, then reset mid-stall
        issue(OP_ADD, 4'd4, 4'd3, 1'b1, 8'h00);
        tick();
        chk("t6_refill", idex_valid, 1);
        tick();
        chk("t6_stall5", stall_count, 5);
        reset = 1'b1;
        tick();
        chk("t6_rst_v", idex_valid, 0);
        chk("t6_rst_a", idex_a, 0);
        chk("t6_rst_b", idex_b, 0);
        chk("t6_rst_op", idex_op, 0);
        chk("t6_rst_sx", idex_sx_addr, 0);
        chk("t6_rst_st", stall_count, 0);
        chk("sat_rst", s_cnt, 0);
        reset = 1'b0;
        idb.id_valid = 1'b0;
        ex_ready = 1'b1;

        // saturation on the 3-bit counter
        for (int i = 0; i < 3; i++) tick();
        chk("sat_3", s_cnt, 3);
        for (int i = 0; i < 6; i++) tick();
        chk("sat_7", s_cnt, 7);
        chk("sat_novalid", s_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
